// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - three-port DRAM command arbiter with read routing and timeout (option: DRAM_ARB_RR_EN)
module dram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_async,
    input  logic            r0_req,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    input  logic [DW/8-1:0] r0_we,
    output logic            r0_ack,
    input  logic            r1_req,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    input  logic [DW/8-1:0] r1_we,
    output logic            r1_ack,
    input  logic            r2_req,
    input  logic [AW-1:0]   r2_addr,
    input  logic [DW-1:0]   r2_wdata,
    input  logic [DW/8-1:0] r2_we,
    output logic            r2_ack,
    output logic            rd_valid,
    output logic [1:0]      rd_id,
    output logic [DW-1:0]   rd_data,
    output logic            dram_oe,
    output logic [AW-1:0]   dram_addr,
    output logic [DW-1:0]   dram_wdata,
    output logic [DW/8-1:0] dram_we,
    input  logic [DW-1:0]   dram_rdata,
    input  logic            dram_valid,
    input  logic            dram_busy,
    output logic            timeout_err
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t          state;
    logic [2:0]      ack;
    logic [1:0]      grant_id;
    logic [CW-1:0]   cnt;
    logic [2:0]      req;
    logic [AW-1:0]   req_addr  [3];
    logic [DW-1:0]   req_wdata [3];
    logic [BW-1:0]   req_we    [3];
    logic            win_found;
    logic [1:0]      win_idx;

    assign req          = {r2_req, r1_req, r0_req};
    assign req_addr[0]  = r0_addr;
    assign req_addr[1]  = r1_addr;
    assign req_addr[2]  = r2_addr;
    assign req_wdata[0] = r0_wdata;
    assign req_wdata[1] = r1_wdata;
    assign req_wdata[2] = r2_wdata;
    assign req_we[0]    = r0_we;
    assign req_we[1]    = r1_we;
    assign req_we[2]    = r2_we;

    assign r0_ack = ack[0];
    assign r1_ack = ack[1];
    assign r2_ack = ack[2];

`ifdef DRAM_ARB_RR_EN
    // rr_ptr holds the index where the next search starts
    logic [1:0] rr_ptr;

    always_comb begin : rr_search
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end
`else
    always_comb begin
        win_found = |req;
        win_idx   = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    end
`endif

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state       <= IDLE;
            ack         <= '0;
            grant_id    <= '0;
            cnt         <= '0;
            rd_valid    <= 1'b0;
            rd_id       <= '0;
            rd_data     <= '0;
            dram_oe     <= 1'b0;
            dram_addr   <= '0;
            dram_wdata  <= '0;
            dram_we     <= '0;
            timeout_err <= 1'b0;
`ifdef DRAM_ARB_RR_EN
            rr_ptr      <= '0;
`endif
        end else begin
            ack      <= '0;
            dram_oe  <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && !dram_busy) begin
                        grant_id     <= win_idx;
                        dram_addr    <= req_addr[win_idx];
                        dram_wdata   <= req_wdata[win_idx];
                        dram_we      <= req_we[win_idx];
                        dram_oe      <= 1'b1;
                        ack[win_idx] <= 1'b1;
`ifdef DRAM_ARB_RR_EN
                        rr_ptr       <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // writes are posted; only reads wait for data
                    if (dram_we != '0) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (dram_valid) begin
                        rd_valid <= 1'b1;
                        rd_id    <= grant_id;
                        rd_data  <= dram_rdata;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        rd_valid    <= 1'b1;
                        rd_id       <= grant_id;
                        rd_data     <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter (follows DRAM_ARB_RR_EN when defined)
module tb_dram_arbiter;
    logic        clk = 1'b0;
    logic        rst_async;
    logic        r0_req, r1_req, r2_req;
    logic [31:0] r0_addr, r1_addr, r2_addr;
    logic [31:0] r0_wdata, r1_wdata, r2_wdata;
    logic [3:0]  r0_we, r1_we, r2_we;
    logic        r0_ack, r1_ack, r2_ack;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [31:0] rd_data;
    logic        dram_oe;
    logic [31:0] dram_addr, dram_wdata;
    logic [3:0]  dram_we;
    logic [31:0] dram_rdata;
    logic        dram_valid, dram_busy;
    logic        timeout_err;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } cmd_t;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   errors = 0;
    int   checks = 0;

    dram_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_async(rst_async),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_we(r0_we), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_we(r1_we), .r1_ack(r1_ack),
        .r2_req(r2_req), .r2_addr(r2_addr), .r2_wdata(r2_wdata), .r2_we(r2_we), .r2_ack(r2_ack),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_busy(dram_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] w, input logic en);
        case (id)
            0: begin r0_req = en; r0_addr = a; r0_wdata = d; r0_we = w; end
            1: begin r1_req = en; r1_addr = a; r1_wdata = d; r1_we = w; end
            default: begin r2_req = en; r2_addr = a; r2_wdata = d; r2_we = w; end
        endcase
    endtask

    task automatic push_cmd(input int id, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        cmd_t c;
        c.id = 2'(id); c.addr = a; c.wdata = d; c.we = w;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input int id, input logic [31:0] d);
        rsp_t r;
        r.id = 2'(id); r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {r0_ack, r1_ack, r2_ack, rd_valid, rd_id, rd_data, dram_oe,
                    dram_addr, dram_wdata, dram_we, timeout_err}, '0);
    endtask

    // waits for the next dram_oe and compares it with the oldest expected command
    task automatic wait_cmd(input string tag, input int exp_lat);
        int   lat;
        cmd_t e;
        logic [2:0] ack_exp;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dram_oe && lat < 20);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_queued"}, (cmd_q.size() > 0), 1);
        if (cmd_q.size() > 0) begin
            e = cmd_q.pop_front();
            ack_exp = 3'b001 << e.id;
            check({tag, "_cmd"}, {r2_ack, r1_ack, r0_ack, dram_oe, dram_addr, dram_wdata, dram_we},
                  {ack_exp, 1'b1, e.addr, e.wdata, e.we});
        end
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int   lat;
        rsp_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rd_valid && lat < 40);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_queued"}, (rsp_q.size() > 0), 1);
        if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            check({tag, "_rsp"}, {rd_valid, rd_id, rd_data}, {1'b1, e.id, e.data});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[$];
        rst_async = 1'b1;
        dram_rdata = '0; dram_valid = 1'b0; dram_busy = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        rst_async = 1'b0;

        // all three requesters writing at once, r0 held through several grants
`ifdef DRAM_ARB_RR_EN
        exp_seq = '{0, 1, 2, 0};
`else
        exp_seq = '{0, 0, 0, 1, 2};
`endif
        for (int id = 0; id < 3; id++)
            set_req(id, 32'h1000 * (id + 1), 32'hC0DE_0000 + id, 4'hF, 1'b1);
        for (int i = 0; i < exp_seq.size(); i++) begin
            int  id;
            logic more;
            id = exp_seq[i];
            push_cmd(id, 32'h1000 * (id + 1), 32'hC0DE_0000 + id, 4'hF);
            wait_cmd($sformatf("prio%0d", i), (i == 0) ? 1 : 2);
            more = 1'b0;
            for (int j = i + 1; j < exp_seq.size(); j++)
                if (exp_seq[j] == id) more = 1'b1;
            if (!more) set_req(id, '0, '0, '0, 1'b0);
        end
        repeat (2) @(negedge clk);

        // single posted write on r1
        set_req(1, 32'h100, 32'hA5A5A5A5, 4'hF, 1'b1);
        push_cmd(1, 32'h100, 32'hA5A5A5A5, 4'hF);
        wait_cmd("wr1", 1);
        set_req(1, '0, '0, '0, 1'b0);
        @(negedge clk);
        check("wr1_strobe_len", {dram_oe, r1_ack}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr1_no_rsp", rd_valid, 1'b0);
        end

        // read on r2, data returned 5 cycles after the command
        set_req(2, 32'h40, '0, 4'h0, 1'b1);
        push_cmd(2, 32'h40, '0, 4'h0);
        wait_cmd("rd2", 1);
        set_req(2, '0, '0, '0, 1'b0);
        push_rsp(2, 32'h12345678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rd2_early", rd_valid, 1'b0);
        end
        dram_valid = 1'b1; dram_rdata = 32'h12345678;
        wait_rsp("rd2", 1);
        dram_valid = 1'b0;
        repeat (2) @(negedge clk);

        // controller busy holds off a pending request
        dram_busy = 1'b1;
        set_req(1, 32'h200, 32'h5A5A0001, 4'h3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("busy_hold", {dram_oe, r1_ack}, 2'b00);
        end
        dram_busy = 1'b0;
        push_cmd(1, 32'h200, 32'h5A5A0001, 4'h3);
        wait_cmd("busy_release", 1);
        set_req(1, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // read that never returns: timeout after 16 cycles in WAIT_RD
        set_req(0, 32'h80, '0, 4'h0, 1'b1);
        push_cmd(0, 32'h80, '0, 4'h0);
        wait_cmd("to_cmd", 1);
        set_req(0, '0, '0, '0, 1'b0);
        check("to_err_before", timeout_err, 1'b0);
        push_rsp(0, 32'h0);
        wait_rsp("to", 17);
        check("to_err_set", timeout_err, 1'b1);
        dram_valid = 1'b1; dram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dram_valid = 1'b0;
        @(negedge clk);
        check("to_late_valid", {rd_valid, timeout_err}, 2'b01);
        repeat (2) @(negedge clk);

        // reset in the middle of a read discards the response
        set_req(2, 32'hC0, '0, 4'h0, 1'b1);
        push_cmd(2, 32'hC0, '0, 4'h0);
        wait_cmd("rst_rd", 1);
        set_req(2, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst_async = 1'b1;
        #1;
        check_zero("rst_midread");
        @(negedge clk);
        rst_async = 1'b0;
        dram_valid = 1'b1; dram_rdata = 32'h0BADF00D;
        @(negedge clk);
        dram_valid = 1'b0;
        check("rst_discard", rd_valid, 1'b0);
        @(negedge clk);
        check("rst_discard2", rd_valid, 1'b0);

        set_req(1, 32'h300, '0, 4'h0, 1'b1);
        push_cmd(1, 32'h300, '0, 4'h0);
        wait_cmd("post_rst", 1);
        set_req(1, '0, '0, '0, 1'b0);
        push_rsp(1, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        dram_valid = 1'b1; dram_rdata = 32'hCAFEF00D;
        wait_rsp("post_rst", 1);
        dram_valid = 1'b0;

        check("cmd_q_drained", cmd_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
